// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 device-to-host receive path.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

  localparam int unsigned FRAME_DATA_BITS = 8;
  localparam int unsigned SYNC_STAGES     = 2;

  // True when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [FRAME_DATA_BITS-1:0] data,
                                         input logic                       parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 clock conditioning: synchroniser, level debounce and filtered falling-edge strobe.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   filt;
  logic                   line_s;
  logic                   flip;

  assign line_s = sync_q[SYNC_STAGES-1];
  // cnt holds how many consecutive samples already disagreed; this one is the last needed.
  assign flip   = (line_s != filt) && (cnt == CW'(FILTER_LEN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      cnt    <= '0;
      filt   <= 1'b1;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
      fall   <= flip && !line_s;
      if (flip) begin
        filt <= line_s;
        cnt  <= '0;
      end else if (line_s != filt) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_packet_rx.sv
// PS/2 receiver: deframes 11-bit frames, assembles packets, valid/ready output with inhibit.
module ps2_packet_rx
  import ps2_pkg::*;
#(
  parameter int unsigned PACKET_BYTES   = 3,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter bit          ALIGN_BIT3     = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ps2_clk_in,
  input  logic                      ps2_data_in,
  output logic                      ps2_clk_inhibit,
  output logic [8*PACKET_BYTES-1:0] packet_data,
  output logic                      packet_valid,
  input  logic                      packet_ready,
  output logic                      parity_err,
  output logic                      framing_err,
  output logic                      overflow
);

  localparam int unsigned IW = (PACKET_BYTES > 1) ? $clog2(PACKET_BYTES) : 1;
  localparam int unsigned BW = $clog2(FRAME_DATA_BITS);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic                             fall;
  logic [SYNC_STAGES-1:0]           data_sync;
  logic                             data_s;
  frame_state_t                     state;
  logic [BW-1:0]                    bit_cnt;
  logic [FRAME_DATA_BITS-1:0]       shift_reg;
  logic                             par_ok;
  logic [IW-1:0]                    byte_idx;
  logic [TW-1:0]                    to_cnt;
  logic [PACKET_BYTES-1:0][7:0]     pkt_buf;
  logic [PACKET_BYTES-1:0][7:0]     pkt_full;
  logic busy, timeout_hit, byte_ok, drop, last_slot, complete, valid_next, quiet_next;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (clk),
    .reset  (reset),
    .line_in(ps2_clk_in),
    .fall   (fall)
  );

  assign data_s = data_sync[SYNC_STAGES-1];

  always_comb begin
    busy        = (state != IDLE) || (byte_idx != '0);
    timeout_hit = !fall && busy && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    byte_ok     = fall && (state == STOP) && data_s && par_ok;
    drop        = ALIGN_BIT3 && (byte_idx == '0) && !shift_reg[3];
    last_slot   = (byte_idx == IW'(PACKET_BYTES - 1));
    complete    = byte_ok && !drop && last_slot;
    pkt_full           = pkt_buf;
    pkt_full[byte_idx] = shift_reg;
    valid_next  = complete || (packet_valid && !packet_ready);
    // Inhibit is registered, so it is derived from where the frame/packet logic lands next.
    quiet_next  = (state == IDLE) && (byte_idx == '0);
    if (timeout_hit) begin
      quiet_next = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE:   quiet_next = data_s && (byte_idx == '0);
        DATA:   quiet_next = 1'b0;
        PARITY: quiet_next = 1'b0;
        STOP:   quiet_next = !byte_ok || drop || last_slot;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_sync       <= '1;
      state           <= IDLE;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      par_ok          <= 1'b0;
      byte_idx        <= '0;
      to_cnt          <= '0;
      pkt_buf         <= '0;
      packet_data     <= '0;
      packet_valid    <= 1'b0;
      ps2_clk_inhibit <= 1'b0;
      parity_err      <= 1'b0;
      framing_err     <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      data_sync   <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overflow    <= 1'b0;

      if (fall || timeout_hit || !busy) to_cnt <= '0;
      else                              to_cnt <= to_cnt + 1'b1;

      if (timeout_hit) begin
        state       <= IDLE;
        byte_idx    <= '0;
        framing_err <= 1'b1;
      end else if (fall) begin
        case (state)
          IDLE: if (!data_s) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            shift_reg <= {data_s, shift_reg[FRAME_DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(FRAME_DATA_BITS - 1)) state <= PARITY;
          end
          PARITY: begin
            par_ok <= odd_parity_ok(shift_reg, data_s);
            state  <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!byte_ok) begin
              byte_idx    <= '0;
              parity_err  <= !par_ok;
              framing_err <= !data_s;
            end else if (!drop) begin
              if (last_slot) begin
                byte_idx <= '0;
              end else begin
                pkt_buf[byte_idx] <= shift_reg;
                byte_idx          <= byte_idx + 1'b1;
              end
            end
          end
        endcase
      end

      if (complete) begin
        if (!packet_valid || packet_ready) begin
          packet_data  <= pkt_full;
          packet_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (packet_valid && packet_ready) begin
        packet_valid <= 1'b0;
      end

      ps2_clk_inhibit <= valid_next && !packet_ready && quiet_next;
    end
  end

endmodule

// File: tb/tb_ps2_packet_rx.sv
// Self-checking bench for ps2_packet_rx: directed scenarios plus a randomised frame stream.
`timescale 1ns/1ps
module tb_ps2_packet_rx;

  localparam int PB    = 3;
  localparam int L     = 8;
  localparam int T     = 400;
  localparam int HALF  = 16;
  localparam bit ALIGN = 1'b1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ps2_clk_in = 1'b1;
  logic          ps2_data_in = 1'b1;
  logic          ps2_clk_inhibit;
  logic [8*PB-1:0] packet_data;
  logic          packet_valid;
  logic          packet_ready = 1'b1;
  logic          parity_err, framing_err, overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int valid_rise_cyc = -1;
  int frm_cyc = -1;
  int par_cnt = 0, frm_cnt = 0, ovf_cnt = 0;
  logic prev_valid;
  logic [8*PB-1:0] acc_q[$];

  // Reference model state: expected packets and error counts from the framing rules.
  int m_idx = 0;
  logic [8*PB-1:0] m_pkt = '0;
  logic [8*PB-1:0] exp_q[$];
  int exp_par = 0, exp_frm = 0;

  ps2_packet_rx #(
    .PACKET_BYTES  (PB),
    .FILTER_LEN    (L),
    .TIMEOUT_CYCLES(T),
    .ALIGN_BIT3    (ALIGN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ps2_clk_in     (ps2_clk_in),
    .ps2_data_in    (ps2_data_in),
    .ps2_clk_inhibit(ps2_clk_inhibit),
    .packet_data    (packet_data),
    .packet_valid   (packet_valid),
    .packet_ready   (packet_ready),
    .parity_err     (parity_err),
    .framing_err    (framing_err),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (packet_valid && packet_ready) acc_q.push_back(packet_data);
      if (packet_valid && !prev_valid) valid_rise_cyc = cyc;
      prev_valid = packet_valid;
      if (parity_err) par_cnt++;
      if (framing_err) begin frm_cnt++; frm_cyc = cyc; end
      if (overflow) ovf_cnt++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit pbad, input bit sbad);
    logic p;
    p = (~^b) ^ pbad;
    return {~sbad, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data_in = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk_in = 1'b0;
      fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk_in = 1'b1;
    end
    ps2_data_in = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit pbad = 1'b0, input bit sbad = 1'b0);
    send_bits(frame_bits(b, pbad, sbad), 11);
    if (pbad || sbad) begin
      m_idx = 0;
      exp_par += int'(pbad);
      exp_frm += int'(sbad);
    end else if (!(ALIGN && m_idx == 0 && !b[3])) begin
      m_pkt[8*m_idx +: 8] = b;
      m_idx++;
      if (m_idx == PB) begin
        exp_q.push_back(m_pkt);
        m_idx = 0;
      end
    end
  endtask

  task automatic drive_ready(input logic v);
    @(posedge clk);
    #1 packet_ready = v;
  endtask

  task automatic test_reset;
    repeat (5) @(negedge clk);
    checks++;
    if ({ps2_clk_inhibit, packet_valid, parity_err, framing_err, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {ps2_clk_inhibit, packet_valid, parity_err, framing_err, overflow});
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (packet_data !== '0 || packet_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: got %h/%b want 000000/0", packet_data, packet_valid);
    end
  endtask

  task automatic test_basic;
    int p0, f0;
    p0 = par_cnt; f0 = frm_cnt; valid_rise_cyc = -1;
    acc_q.delete();
    send_byte(8'h08); send_byte(8'h12); send_byte(8'hFE);
    repeat (4) @(negedge clk);
    checks++;
    if (acc_q.size() != 1 || acc_q[0] !== 24'hFE1208) begin
      errors++;
      $display("FAIL basic_packet: got n=%0d %h want n=1 fe1208", acc_q.size(),
               acc_q.size() > 0 ? acc_q[0] : '0);
    end
    // Two sync stages plus FILTER_LEN samples to the strobe, then one clk to valid.
    checks++;
    if (valid_rise_cyc != fall_cyc + L + 3) begin
      errors++;
      $display("FAIL basic_latency: got %0d want %0d", valid_rise_cyc, fall_cyc + L + 3);
    end
    checks++;
    if (packet_data !== 24'hFE1208) begin
      errors++;
      $display("FAIL basic_hold: got %h want fe1208", packet_data);
    end
    checks++;
    if (par_cnt != p0 || frm_cnt != f0) begin
      errors++;
      $display("FAIL basic_errs: got par=%0d frm=%0d want 0 0", par_cnt - p0, frm_cnt - f0);
    end
  endtask

  task automatic test_parity;
    int p0, f0;
    p0 = par_cnt; f0 = frm_cnt;
    acc_q.delete();
    send_byte(8'h08); send_byte(8'h12); send_byte(8'h34, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (par_cnt - p0 != 1 || frm_cnt != f0) begin
      errors++;
      $display("FAIL parity_pulse: got par=%0d frm=%0d want 1 0", par_cnt - p0, frm_cnt - f0);
    end
    checks++;
    if (acc_q.size() != 0) begin
      errors++;
      $display("FAIL parity_nopkt: got %0d packets want 0", acc_q.size());
    end
    send_byte(8'h08); send_byte(8'h00); send_byte(8'h00);
    repeat (4) @(negedge clk);
    checks++;
    if (acc_q.size() != 1 || acc_q[0] !== 24'h000008) begin
      errors++;
      $display("FAIL parity_recover: got n=%0d want 000008", acc_q.size());
    end
  endtask

  task automatic test_timeout;
    int f0, t0;
    f0 = frm_cnt;
    acc_q.delete();
    send_byte(8'h08);
    send_bits(frame_bits(8'h55, 1'b0, 1'b0), 6);
    t0 = fall_cyc;
    for (int i = 0; i < T + L + 40 && frm_cnt == f0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++;
    if (frm_cnt - f0 != 1) begin
      errors++;
      $display("FAIL timeout_pulse: got %0d pulses want 1", frm_cnt - f0);
    end
    checks++;
    if (frm_cyc != t0 + L + 3 + T) begin
      errors++;
      $display("FAIL timeout_time: got cycle %0d want %0d", frm_cyc, t0 + L + 3 + T);
    end
    m_idx = 0;
    send_byte(8'h18); send_byte(8'h22); send_byte(8'h33);
    repeat (4) @(negedge clk);
    checks++;
    if (acc_q.size() != 1 || acc_q[0] !== 24'h332218) begin
      errors++;
      $display("FAIL timeout_recover: got n=%0d want 332218", acc_q.size());
    end
  endtask

  task automatic test_backpressure;
    int o0;
    o0 = ovf_cnt;
    acc_q.delete();
    drive_ready(1'b0);
    send_byte(8'h09); send_byte(8'h02); send_byte(8'h03);
    repeat (4) @(negedge clk);
    checks++;
    if (packet_valid !== 1'b1 || packet_data !== 24'h030209 || ps2_clk_inhibit !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: got v=%b d=%h inh=%b want 1 030209 1",
               packet_valid, packet_data, ps2_clk_inhibit);
    end
    send_byte(8'h0A);
    repeat (2) @(negedge clk);
    checks++;
    if (ps2_clk_inhibit !== 1'b0) begin
      errors++;
      $display("FAIL bp_midpacket_inhibit: got %b want 0", ps2_clk_inhibit);
    end
    send_byte(8'h0B); send_byte(8'h0C);
    repeat (4) @(negedge clk);
    checks++;
    if (ovf_cnt - o0 != 1 || packet_data !== 24'h030209 || ps2_clk_inhibit !== 1'b1) begin
      errors++;
      $display("FAIL bp_overflow: got ovf=%0d d=%h inh=%b want 1 030209 1",
               ovf_cnt - o0, packet_data, ps2_clk_inhibit);
    end
    drive_ready(1'b1);
    @(posedge clk);
    #1 packet_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (packet_valid !== 1'b0 || ps2_clk_inhibit !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got v=%b inh=%b want 0 0", packet_valid, ps2_clk_inhibit);
    end
    checks++;
    if (acc_q.size() != 1 || acc_q[0] !== 24'h030209) begin
      errors++;
      $display("FAIL bp_accepted: got n=%0d want 1x030209", acc_q.size());
    end
    drive_ready(1'b1);
    exp_q.delete();
  endtask

  task automatic test_align;
    acc_q.delete();
    send_byte(8'h00); send_byte(8'h08); send_byte(8'h11); send_byte(8'h22);
    repeat (4) @(negedge clk);
    checks++;
    if (acc_q.size() != 1 || acc_q[0] !== 24'h221108) begin
      errors++;
      $display("FAIL align: got n=%0d %h want 221108", acc_q.size(),
               acc_q.size() > 0 ? acc_q[0] : '0);
    end
  endtask

  task automatic test_glitch;
    int p0, f0;
    p0 = par_cnt; f0 = frm_cnt;
    acc_q.delete();
    ps2_data_in = 1'b0;
    @(negedge clk);
    ps2_clk_in = 1'b0;
    repeat (L - 1) @(negedge clk);
    ps2_clk_in = 1'b1;
    repeat (40) @(negedge clk);
    ps2_data_in = 1'b1;
    send_byte(8'h28); send_byte(8'h5A); send_byte(8'hC3);
    repeat (4) @(negedge clk);
    checks++;
    if (acc_q.size() != 1 || acc_q[0] !== 24'hC35A28 || par_cnt != p0 || frm_cnt != f0) begin
      errors++;
      $display("FAIL glitch: got n=%0d par=%0d frm=%0d want c35a28 0 0",
               acc_q.size(), par_cnt - p0, frm_cnt - f0);
    end
  endtask

  task automatic test_reset_mid;
    acc_q.delete();
    send_bits(frame_bits(8'hA5, 1'b0, 1'b0), 5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ps2_clk_inhibit, packet_valid, parity_err, framing_err, overflow} !== 5'b0 ||
        packet_data !== '0) begin
      errors++;
      $display("FAIL reset_mid: got ctrl=%b d=%h want 00000 000000",
               {ps2_clk_inhibit, packet_valid, parity_err, framing_err, overflow}, packet_data);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_idx = 0;
    repeat (5) @(negedge clk);
    send_byte(8'h48); send_byte(8'h33); send_byte(8'h77);
    repeat (4) @(negedge clk);
    checks++;
    if (acc_q.size() != 1 || acc_q[0] !== 24'h773348) begin
      errors++;
      $display("FAIL reset_mid_recover: got n=%0d want 773348", acc_q.size());
    end
  endtask

  task automatic test_random;
    int p0, f0, o0;
    logic [7:0] b;
    bit pbad, sbad;
    p0 = par_cnt; f0 = frm_cnt; o0 = ovf_cnt;
    exp_par = 0; exp_frm = 0; m_idx = 0;
    acc_q.delete(); exp_q.delete();
    for (int n = 0; n < 18; n++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 1) b[3] = 1'b1;
      pbad = ($urandom_range(0, 7) == 0);
      sbad = ($urandom_range(0, 7) == 0);
      send_byte(b, pbad, sbad);
    end
    repeat (T + L + 50) @(negedge clk);
    if (m_idx != 0) begin
      exp_frm++;
      m_idx = 0;
    end
    checks++;
    if (acc_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d packets want %0d", acc_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_pkt%0d: got %h want %h", i, acc_q[i], exp_q[i]);
      end
    end
    checks++;
    if (par_cnt - p0 != exp_par || frm_cnt - f0 != exp_frm || ovf_cnt != o0) begin
      errors++;
      $display("FAIL rand_errs: got par=%0d frm=%0d ovf=%0d want %0d %0d 0",
               par_cnt - p0, frm_cnt - f0, ovf_cnt - o0, exp_par, exp_frm);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_timeout;
    test_backpressure;
    test_align;
    test_glitch;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
